// File: rtl/piso_tx_pkg.sv
// rtl/piso_tx_pkg.sv - shared types and helpers for the piso_tx_sched scheduler
//
// Purpose : FSM state encoding, requester id constants and the two-way
//           round-robin pick used by the scheduler.
// Contents: state_e (IDLE, SHIFT), REQ0/REQ1, arb_pick().
package piso_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Returns the id of the requester to grant. A lone valid requester always
  // wins; with both valid the round-robin pointer decides. With neither
  // valid the result is don't-care (callers qualify it with valid).
  function automatic logic arb_pick(input logic v0, input logic v1, input logic rr);
    logic pick;
    if (v0 && v1) begin
      pick = rr;
    end else if (v1) begin
      pick = REQ1;
    end else begin
      pick = REQ0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// rtl/piso_shift_core.sv - WIDTH-bit parallel-load, shift-left register
//
// Purpose : Holds the word being serialised. load_i captures data_i,
//           shift_en_i shifts left by one with zero fill. load wins over
//           shift if both are asserted.
// Ports   : clk, rst_n (async active-low), load_i, shift_en_i,
//           data_i[WIDTH-1:0], msb_o (current MSB of the register).
module piso_shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_en_i) begin
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/piso_tx_sched.sv
// rtl/piso_tx_sched.sv - two-requester round-robin scheduler feeding a PISO shifter
//
// Purpose : Arbitrates between two parallel word sources, loads the granted
//           word and shifts it out MSB-first on a valid/ready serial lane,
//           flagging the final (LSB) bit.
// Macro   : PISO_TX_SCHED_B2B_EN - when defined, a new word may be accepted
//           on the edge that consumes the last bit of the current word,
//           removing the idle bubble between words.
// Ports   : clk, reset (async active-low)
//           req0_valid/req0_data/req0_ready   requester 0 word handshake
//           req1_valid/req1_data/req1_ready   requester 1 word handshake
//           sout/sout_valid/sout_last/sout_ready  serial output handshake
//           grant_id  source of the word in flight
//           busy      high while shifting
module piso_tx_sched
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  input  logic             sout_ready,
  output logic             grant_id,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_q, grant_d;
  logic             rr_q, rr_d;

  logic             arb_window;
  logic             pick;
  logic             accept;
  logic             bit_xfer;
  logic             last_bit;
  logic             shift_en;
  logic [WIDTH-1:0] load_data;
  logic             core_msb;

  assign last_bit = (cnt_q == '0);
  assign bit_xfer = (state_q == SHIFT) && sout_ready;

  // Cycles in which a new word may be taken.
`ifdef PISO_TX_SCHED_B2B_EN
  assign arb_window = (state_q == IDLE) ||
                      ((state_q == SHIFT) && last_bit && sout_ready);
`else
  assign arb_window = (state_q == IDLE);
`endif

  assign pick       = arb_pick(req0_valid, req1_valid, rr_q);
  assign req0_ready = arb_window && req0_valid && (pick == REQ0);
  assign req1_ready = arb_window && req1_valid && (pick == REQ1);
  // Each ready already includes its own valid, so either one means a handshake.
  assign accept     = req0_ready || req1_ready;
  assign load_data  = (pick == REQ1) ? req1_data : req0_data;

  // The last bit is never shifted out of the register: the word either ends
  // (register contents no longer visible) or is replaced by a load.
  assign shift_en   = bit_xfer && !last_bit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = CNT_W'(WIDTH - 1);
      grant_d = pick;
      rr_d    = ~pick;
    end else if (bit_xfer) begin
      if (last_bit) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= REQ0;
      rr_q    <= REQ0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  piso_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (accept),
    .shift_en_i (shift_en),
    .data_i     (load_data),
    .msb_o      (core_msb)
  );

  // Serial outputs are decoded from registered state only; sout is forced
  // low in IDLE because the register still holds the previous LSB there.
  assign sout       = (state_q == SHIFT) && core_msb;
  assign sout_valid = (state_q == SHIFT);
  assign sout_last  = (state_q == SHIFT) && last_bit;
  assign busy       = (state_q == SHIFT);
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_piso_tx_sched.sv
// tb/tb_piso_tx_sched.sv - directed self-checking bench for piso_tx_sched
module tb_piso_tx_sched;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         sout, sout_valid, sout_last, sout_ready;
  logic         grant_id, busy;

  piso_tx_sched #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_last  (sout_last),
    .sout_ready (sout_ready),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Producer word queues: valid while non-empty, front word popped on handshake.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  // Per-cycle observations (sampled on the falling edge).
  logic obs_v[64], obs_s[64], obs_l[64], obs_b[64], obs_g[64], obs_r0[64], obs_r1[64];
  // Bits actually consumed downstream.
  logic del_bit[64], del_grant[64], del_last[64];
  int   del_n;
  int   rdy_pat[64];
  int   rdy_len = 0;

  task automatic drive_reqs();
    req0_valid = (q0.size() > 0);
    req0_data  = (q0.size() > 0) ? q0[0] : '0;
    req1_valid = (q1.size() > 0);
    req1_data  = (q1.size() > 0) ? q1[0] : '0;
  endtask

  // Runs n cycles starting just after a rising edge; records outputs only.
  task automatic capture(input int n);
    del_n = 0;
    for (int c = 0; c < n; c++) begin
      drive_reqs();
      sout_ready = (c < rdy_len) ? rdy_pat[c][0] : 1'b1;
      @(negedge clk);
      obs_v[c]  = sout_valid;
      obs_s[c]  = sout;
      obs_l[c]  = sout_last;
      obs_b[c]  = busy;
      obs_g[c]  = grant_id;
      obs_r0[c] = req0_ready;
      obs_r1[c] = req1_ready;
      if (sout_valid && sout_ready) begin
        del_bit[del_n]   = sout;
        del_grant[del_n] = grant_id;
        del_last[del_n]  = sout_last;
        del_n++;
      end
      @(posedge clk);
      #1;
      if (obs_r0[c] && req0_valid) q0.delete(0);
      if (obs_r1[c] && req1_valid) q1.delete(0);
    end
    drive_reqs();
    rdy_len = 0;
    sout_ready = 1'b1;
  endtask

  // which: 0 = bits, 1 = grants, 2 = last flags; first delivered item is MSB.
  function automatic logic [31:0] pack_del(input int which);
    logic [31:0] r = '0;
    for (int i = 0; i < del_n; i++) begin
      case (which)
        0:       r = {r[30:0], del_bit[i]};
        1:       r = {r[30:0], del_grant[i]};
        default: r = {r[30:0], del_last[i]};
      endcase
    end
    return r;
  endfunction

  task automatic do_reset();
    q0.delete();
    q1.delete();
    drive_reqs();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    q0.delete();
    q1.delete();
    drive_reqs();
    sout_ready = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    got = {sout, sout_valid, sout_last, busy, grant_id, req0_ready, req1_ready};
    if (got !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", got, 7'b0);
    end
    reset = 1'b1;
    capture(2);
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({obs_v[c], obs_b[c], obs_s[c]} !== 3'b000) begin
        failures++;
        $display("FAIL reset_idle c=%0d got=%b exp=000", c, {obs_v[c], obs_b[c], obs_s[c]});
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] word = 4'b1010;
    logic [4:0] got, exp;
    q0.push_back(word);
    capture(6);
    checks++;
    if ({obs_r0[0], obs_r1[0], obs_r0[1]} !== 3'b100) begin
      failures++;
      $display("FAIL single_ready got=%b exp=100", {obs_r0[0], obs_r1[0], obs_r0[1]});
    end
    for (int c = 1; c <= 5; c++) begin
      got = {obs_v[c], obs_s[c], obs_l[c], obs_b[c], obs_g[c]};
      if (c <= 4) exp = {1'b1, word[4-c], (c == 4), 1'b1, 1'b0};
      else        exp = 5'b00000;
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL single_cycle c=%0d got=%b exp=%b", c, got, exp);
      end
    end
    checks++;
    if (del_n !== 4 || pack_del(0) !== 32'hA) begin
      failures++;
      $display("FAIL single_bits n=%0d got=%h exp=a", del_n, pack_del(0));
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [6:0] got;
    q1.push_back(4'b1100);
    capture(3);
    checks++;
    if ({del_n == 2, busy, grant_id} !== 3'b111) begin
      failures++;
      $display("FAIL midreset_pre n=%0d busy=%b grant=%b exp n=2 busy=1 grant=1", del_n, busy, grant_id);
    end
    reset = 1'b0;
    #1;
    checks++;
    got = {sout, sout_valid, sout_last, busy, grant_id, req0_ready, req1_ready};
    if (got !== 7'b0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b exp=%b", got, 7'b0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    q0.push_back(4'b0110);
    capture(6);
    checks++;
    if ({obs_v[0], obs_r0[0]} !== 2'b01) begin
      failures++;
      $display("FAIL midreset_flush got=%b exp=01", {obs_v[0], obs_r0[0]});
    end
    checks++;
    if (del_n !== 4 || pack_del(0) !== 32'h6 || pack_del(1) !== 32'h0) begin
      failures++;
      $display("FAIL midreset_word n=%0d bits=%h grants=%h exp bits=6 grants=0", del_n, pack_del(0), pack_del(1));
    end
  endtask

  task automatic test_round_robin();
    int k;
    do_reset();
    q0.push_back(4'b1100);
    q0.push_back(4'b1010);
    q1.push_back(4'b0011);
`ifdef PISO_TX_SCHED_B2B_EN
    k = 4;
`else
    k = 5;
`endif
    capture(16);
    checks++;
    if ({obs_r0[0], obs_r1[0]} !== 2'b10) begin
      failures++;
      $display("FAIL rr_first got=%b exp=10", {obs_r0[0], obs_r1[0]});
    end
    checks++;
    if ({obs_r0[k], obs_r1[k]} !== 2'b01) begin
      failures++;
      $display("FAIL rr_second c=%0d got=%b exp=01", k, {obs_r0[k], obs_r1[k]});
    end
    checks++;
    if (del_n !== 12 || pack_del(0) !== 32'hC3A) begin
      failures++;
      $display("FAIL rr_bits n=%0d got=%h exp=c3a", del_n, pack_del(0));
    end
    checks++;
    if (pack_del(1) !== 32'h0F0) begin
      failures++;
      $display("FAIL rr_grants got=%h exp=0f0", pack_del(1));
    end
    checks++;
    if (pack_del(2) !== 32'h111) begin
      failures++;
      $display("FAIL rr_last got=%h exp=111", pack_del(2));
    end
  endtask

  task automatic test_stall();
    logic [2:0] got, exp;
    logic [8:0] exp_s = 9'b0_1000_0110;
    logic [8:0] exp_l = 9'b0_0000_0110;
    int pat[8] = '{1, 1, 0, 0, 1, 1, 0, 1};
    for (int i = 0; i < 8; i++) rdy_pat[i] = pat[i];
    rdy_len = 8;
    q0.push_back(4'b1001);
    capture(9);
    for (int c = 1; c <= 8; c++) begin
      got = {obs_v[c], obs_s[c], obs_l[c]};
      exp = {(c <= 7), exp_s[8-c], exp_l[8-c]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL stall_cycle c=%0d got=%b exp=%b", c, got, exp);
      end
    end
    checks++;
    if (del_n !== 4 || pack_del(0) !== 32'h9) begin
      failures++;
      $display("FAIL stall_bits n=%0d got=%h exp=9", del_n, pack_del(0));
    end
  endtask

  task automatic test_back_to_back();
    int first, last, nv, gaps, exp_gaps;
    q1.push_back(4'b1111);
    q1.push_back(4'b0001);
    capture(11);
    first = -1;
    last = -1;
    nv = 0;
    for (int c = 0; c < 11; c++) begin
      if (obs_v[c]) begin
        if (first < 0) first = c;
        last = c;
        nv++;
      end
    end
    gaps = (last - first + 1) - nv;
`ifdef PISO_TX_SCHED_B2B_EN
    exp_gaps = 0;
`else
    exp_gaps = 1;
`endif
    checks++;
    if (first !== 1 || nv !== 8) begin
      failures++;
      $display("FAIL b2b_valid first=%0d count=%0d exp first=1 count=8", first, nv);
    end
    checks++;
    if (gaps !== exp_gaps) begin
      failures++;
      $display("FAIL b2b_gap got=%0d exp=%0d", gaps, exp_gaps);
    end
    checks++;
    if (del_n !== 8 || pack_del(0) !== 32'hF1 || pack_del(1) !== 32'hFF) begin
      failures++;
      $display("FAIL b2b_bits n=%0d bits=%h grants=%h exp bits=f1 grants=ff", del_n, pack_del(0), pack_del(1));
    end
  endtask

  initial begin
    reset = 1'b0;
    sout_ready = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = '0;
    req1_data = '0;
    test_reset();
    test_single();
    test_reset_mid_shift();
    test_round_robin();
    test_stall();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
